// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - loadable program memory issuing one instruction per fixed-length slot to cpu_top
// Optional breakpoint (bp_en/bp_addr/bp_hit) is built when INSTR_SEQ_BREAKPOINT_EN is defined.
module instr_sequencer #(
    parameter int INSTR_W       = 11,
    parameter int DEPTH         = 256,
    parameter int AW            = 8,
    parameter int CYC_PER_INSTR = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_en,
    input  logic [AW-1:0]      load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic [AW:0]        prog_len,
    input  logic               start,
    input  logic               step_mode,
    input  logic               step,
    input  logic               abort,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic               slot_first,
    output logic [AW-1:0]      pc,
    output logic               busy,
    output logic               done,
`ifdef INSTR_SEQ_BREAKPOINT_EN
    input  logic               bp_en,
    input  logic [AW-1:0]      bp_addr,
    output logic               bp_hit,
`endif
    output logic               load_err
);

    localparam int PW = (CYC_PER_INSTR > 1) ? $clog2(CYC_PER_INSTR) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(CYC_PER_INSTR - 1);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_STEP, S_DONE} state_t;

    state_t               state_q, state_n;
    logic [AW-1:0]        pc_q, pc_n;
    logic [PW-1:0]        phase_q, phase_n;
    logic [AW:0]          len_q, len_n;
    logic [INSTR_W-1:0]   instr_q;
    logic                 new_slot;
    logic                 load_err_q;
    logic [INSTR_W-1:0]   mem [DEPTH];

    logic [AW:0]   eff_len;
    logic          last_slot;
    logic          slot_end;
    logic [AW-1:0] pc_inc;
    logic          load_state_ok;
    logic          load_addr_ok;
    logic          bp_match_zero;
    logic          bp_match_next;

    assign eff_len       = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;
    assign last_slot     = ({1'b0, pc_q} == (len_q - 1'b1));
    assign slot_end      = (phase_q == PH_LAST);
    assign pc_inc        = pc_q + 1'b1;
    assign load_state_ok = (state_q == S_IDLE) || (state_q == S_DONE);
    assign load_addr_ok  = ({1'b0, load_addr} < DEPTH_W);

`ifdef INSTR_SEQ_BREAKPOINT_EN
    assign bp_match_zero = bp_en && (bp_addr == '0);
    assign bp_match_next = bp_en && (bp_addr == pc_inc);
`else
    assign bp_match_zero = 1'b0;
    assign bp_match_next = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            phase_q    <= '0;
            len_q      <= '0;
            instr_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            pc_q       <= pc_n;
            phase_q    <= phase_n;
            len_q      <= len_n;
            load_err_q <= load_en && !(load_state_ok && load_addr_ok);
            // Latch the slot's instruction once so it stays stable for the whole slot
            if (new_slot)
                instr_q <= mem[pc_n];
            else if (state_n != S_ISSUE)
                instr_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (load_en && load_state_ok && load_addr_ok)
            mem[load_addr] <= load_data;
    end

    always_comb begin
        state_n  = state_q;
        pc_n     = pc_q;
        phase_n  = phase_q;
        len_n    = len_q;
        new_slot = 1'b0;
        if (abort) begin
            state_n = S_IDLE;
            pc_n    = '0;
            phase_n = '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        len_n   = eff_len;
                        pc_n    = '0;
                        phase_n = '0;
                        if (eff_len == '0) begin
                            state_n = S_DONE;
                        end else if (bp_match_zero) begin
                            state_n = S_WAIT_STEP;
                        end else begin
                            state_n  = S_ISSUE;
                            new_slot = 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (slot_end) begin
                        phase_n = '0;
                        if (last_slot) begin
                            state_n = S_DONE;
                        end else begin
                            pc_n = pc_inc;
                            if (bp_match_next || step_mode) begin
                                state_n = S_WAIT_STEP;
                            end else begin
                                new_slot = 1'b1;
                            end
                        end
                    end else begin
                        phase_n = phase_q + 1'b1;
                    end
                end
                S_WAIT_STEP: begin
                    // A released slot never re-triggers the breakpoint it was paused on
                    if (step) begin
                        state_n  = S_ISSUE;
                        new_slot = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        instr_valid = (state_q == S_ISSUE);
        slot_first  = instr_valid && (phase_q == '0);
        busy        = (state_q == S_ISSUE) || (state_q == S_WAIT_STEP);
        done        = (state_q == S_DONE);
        instruction = instr_valid ? instr_q : '0;
    end

    assign pc       = pc_q;
    assign load_err = load_err_q;

`ifdef INSTR_SEQ_BREAKPOINT_EN
    logic bp_hit_q, bp_hit_n;

    always_comb begin
        bp_hit_n = bp_hit_q;
        if (abort)
            bp_hit_n = 1'b0;
        else if (state_q == S_WAIT_STEP)
            bp_hit_n = step ? 1'b0 : bp_hit_q;
        else if (state_n == S_WAIT_STEP)
            bp_hit_n = (state_q == S_ISSUE) ? bp_match_next : bp_match_zero;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bp_hit_q <= 1'b0;
        else
            bp_hit_q <= bp_hit_n;
    end

    assign bp_hit = bp_hit_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

    logic        clk;
    logic        reset_n;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [10:0] load_data;
    logic [8:0]  prog_len;
    logic        start;
    logic        step_mode;
    logic        step;
    logic        abort;
    logic [10:0] instruction;
    logic        instr_valid;
    logic        slot_first;
    logic [7:0]  pc;
    logic        busy;
    logic        done;
    logic        load_err;
`ifdef INSTR_SEQ_BREAKPOINT_EN
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic        bp_hit;
`endif

    int n_pass  = 0;
    int n_total = 0;
    logic [10:0] exp_mem [256];

    instr_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .prog_len    (prog_len),
        .start       (start),
        .step_mode   (step_mode),
        .step        (step),
        .abort       (abort),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .slot_first  (slot_first),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
`ifdef INSTR_SEQ_BREAKPOINT_EN
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .bp_hit      (bp_hit),
`endif
        .load_err    (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [10:0] d);
        load_addr = a;
        load_data = d;
        load_en   = 1'b1;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_slot(input int p, input logic [10:0] exp_instr);
        for (int c = 0; c < 3; c++) begin
            check("slot_instr", 32'(instruction), 32'(exp_instr));
            check("slot_valid", 32'(instr_valid), 1);
            check("slot_first", 32'(slot_first), (c == 0) ? 1 : 0);
            check("slot_pc", 32'(pc), p);
            tick();
        end
    endtask

    task automatic wait_done(input int max_cyc);
        int n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        check("wait_done", 32'(done), 1);
    endtask

    initial begin
        int n_valid;
        int n_first;
        int bad;
        int seen_valid;

        reset_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        prog_len = '0; start = 1'b0; step_mode = 1'b0; step = 1'b0; abort = 1'b0;
`ifdef INSTR_SEQ_BREAKPOINT_EN
        bp_en = 1'b0; bp_addr = '0;
`endif
        for (int i = 0; i < 256; i++) exp_mem[i] = 11'((i * 37 + 11) % 2048);
        exp_mem[0] = 11'h123; exp_mem[1] = 11'h456; exp_mem[2] = 11'h789;

        repeat (2) @(posedge clk);
        #1;
        check("rst_instruction", 32'(instruction), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_first", 32'(slot_first), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_load_err", 32'(load_err), 0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 256; i++) load(8'(i), exp_mem[i]);
        check("idle_load_err", 32'(load_err), 0);

        // Free-running three-slot program
        prog_len = 9'd3;
        pulse_start();
        check("run_busy", 32'(busy), 1);
        check_slot(0, 11'h123);
        check_slot(1, 11'h456);
        check_slot(2, 11'h789);
        check("run_done", 32'(done), 1);
        check("run_end_valid", 32'(instr_valid), 0);
        check("run_end_instr", 32'(instruction), 0);
        check("run_end_pc", 32'(pc), 2);
        check("run_end_busy", 32'(busy), 0);

        // Single-step
        step_mode = 1'b1;
        pulse_start();
        check("step_done_clr", 32'(done), 0);
        check_slot(0, 11'h123);
        check("wait_pc", 32'(pc), 1);
        check("wait_instr", 32'(instruction), 0);
        check("wait_valid", 32'(instr_valid), 0);
        check("wait_busy", 32'(busy), 1);
        tick(); tick();
        check("wait_hold_valid", 32'(instr_valid), 0);
        check("wait_hold_pc", 32'(pc), 1);
        step = 1'b1; tick(); step = 1'b0;
        check_slot(1, 11'h456);
        check("wait2_pc", 32'(pc), 2);
        check("wait2_valid", 32'(instr_valid), 0);
        step = 1'b1; tick(); step = 1'b0;
        check_slot(2, 11'h789);
        check("step_done", 32'(done), 1);
        step_mode = 1'b0;

        // Abort on phase 1 of slot 1, then rerun
        pulse_start();
        check_slot(0, 11'h123);
        tick();
        check("abort_pre_first", 32'(slot_first), 0);
        check("abort_pre_pc", 32'(pc), 1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_pc", 32'(pc), 0);
        check("abort_instr", 32'(instruction), 0);
        check("abort_valid", 32'(instr_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        pulse_start();
        check("rerun_instr", 32'(instruction), 32'h123);
        wait_done(20);

        // Rejected load while busy
        pulse_start();
        load_addr = 8'd0; load_data = 11'h7ff; load_en = 1'b1;
        tick();
        load_en = 1'b0;
        check("busy_load_err", 32'(load_err), 1);
        tick();
        check("load_err_pulse", 32'(load_err), 0);
        wait_done(20);
        load(8'd2, 11'h789);
        check("done_load_err", 32'(load_err), 0);
        pulse_start();
        check("mem_unchanged", 32'(instruction), 32'h123);
        check("restart_done_clr", 32'(done), 0);
        wait_done(20);

        // Zero-length program
        abort = 1'b1; tick(); abort = 1'b0;
        check("idle_done", 32'(done), 0);
        prog_len = 9'd0;
        pulse_start();
        check("zero_done", 32'(done), 1);
        check("zero_busy", 32'(busy), 0);
        seen_valid = 0;
        for (int k = 0; k < 4; k++) begin
            if (instr_valid) seen_valid++;
            tick();
        end
        check("zero_no_valid", 32'(seen_valid), 0);

        // Length clamped to DEPTH
        prog_len = 9'd300;
        pulse_start();
        n_valid = 0; n_first = 0; bad = 0;
        for (int k = 0; k < 1000 && done !== 1'b1; k++) begin
            if (instr_valid) n_valid++;
            if (slot_first) begin
                if (instruction !== exp_mem[n_first[7:0]] || pc !== n_first[7:0]) bad++;
                n_first++;
            end
            tick();
        end
        check("long_done", 32'(done), 1);
        check("long_valid_cycles", 32'(n_valid), 768);
        check("long_slots", 32'(n_first), 256);
        check("long_bad_slots", 32'(bad), 0);
        check("long_pc", 32'(pc), 255);

        // Abort and step together while waiting
        prog_len = 9'd3;
        step_mode = 1'b1;
        pulse_start();
        tick(); tick(); tick();
        check("as_wait_busy", 32'(busy), 1);
        check("as_wait_valid", 32'(instr_valid), 0);
        abort = 1'b1; step = 1'b1; tick(); abort = 1'b0; step = 1'b0;
        check("as_busy", 32'(busy), 0);
        check("as_pc", 32'(pc), 0);
        check("as_valid", 32'(instr_valid), 0);
        tick();
        check("as_valid_after", 32'(instr_valid), 0);
        step_mode = 1'b0;

`ifdef INSTR_SEQ_BREAKPOINT_EN
        bp_en = 1'b1; bp_addr = 8'd1;
        pulse_start();
        check_slot(0, 11'h123);
        check("bp_hit", 32'(bp_hit), 1);
        check("bp_pc", 32'(pc), 1);
        check("bp_valid", 32'(instr_valid), 0);
        step = 1'b1; tick(); step = 1'b0;
        check("bp_hit_clr", 32'(bp_hit), 0);
        check_slot(1, 11'h456);
        check_slot(2, 11'h789);
        check("bp_done", 32'(done), 1);
        bp_en = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Synthesizable program sequencer that replaces the bench-side instruction feeder.
- Holds a loadable program memory and issues one instruction per fixed-length slot onto the `instruction` input of `cpu_top`.
- Slot length is `CYC_PER_INSTR`, matching the CPU's Fetch/Exec/Store cycle.
- Adds run / single-step / abort control, a program-length terminator and a done flag.

Parameters:
- `INSTR_W`, 11: instruction width; equals the `cpu_top` instruction width.
- `DEPTH`, 256: program memory entries.
- `AW`, 8: address width; 2^AW >= DEPTH.
- `CYC_PER_INSTR`, 3: clocks per instruction slot; must be >= 1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `load_en`  in  1  write `load_data` into program memory at `load_addr`.
- `load_addr`  in  AW  program memory write address.
- `load_data`  in  INSTR_W  instruction to write.
- `prog_len`  in  AW+1  number of valid instructions, sampled on start.
- `start`  in  1  begin execution from pc 0; a 1-cycle pulse.
- `step_mode`  in  1  1 = pause before every slot after the first.
- `step`  in  1  1-cycle pulse that releases one slot while waiting.
- `abort`  in  1  stop immediately and return to IDLE.
- `instruction`  out  INSTR_W  instruction to the CPU; 0 when no slot is active.
- `instr_valid`  out  1  high for every cycle of an active slot.
- `slot_first`  out  1  high on the first cycle of each slot.
- `pc`  out  AW  address of the current or next slot.
- `busy`  out  1  high in ISSUE or WAIT_STEP.
- `done`  out  1  level; set on program completion, cleared by start or abort.
- `load_err`  out  1  1-cycle pulse when `load_en` is rejected.

Behaviour:
- Reset (`reset_n` low, asynchronous): state IDLE.
  - All outputs 0: `instruction`, `instr_valid`, `slot_first`, `pc`, `busy`, `done`, `load_err`.
  - Phase counter 0. Memory contents are not reset.
- State IDLE:
  - `start` with effective length L>0 → ISSUE next cycle, pc=0, phase=0.
  - `start` with L=0 → DONE next cycle; no slot is issued.
  - L = min(`prog_len`, DEPTH), latched on start.
- State ISSUE:
  - `instruction` = mem[pc], registered and stable for all CYC_PER_INSTR cycles of the slot.
  - `instr_valid`=1 throughout the slot; `slot_first`=1 only when phase=0.
  - Phase counts 0..CYC_PER_INSTR-1.
- Slot end (phase = CYC_PER_INSTR-1):
  - If pc = L-1 → DONE.
  - Else pc <= pc+1. Next state is WAIT_STEP if `step_mode`=1, otherwise ISSUE back-to-back with no idle cycle.
- State WAIT_STEP:
  - `instruction`=0, `instr_valid`=0; `pc` shows the next slot address.
  - `step` → ISSUE next cycle.
  - `step_mode` is re-sampled at every slot end, so clearing it mid-run resumes free-running after the next released slot.
- State DONE:
  - `done`=1, `instruction`=0, `pc` holds L-1.
  - `start` → restart from pc 0 (or stay in DONE if L=0); `done` clears on the cycle ISSUE begins.
- `abort` in any state:
  - Next cycle: IDLE, pc=0, `done`=0, `instruction`=0, phase=0.
  - Mid-slot abort truncates the slot.
  - `abort` has priority over `start` and `step` in the same cycle.
- `start` while busy: ignored. `step` outside WAIT_STEP: ignored.
- Program memory:
  - 1 write port, synchronous.
  - `load_en` is accepted only in IDLE or DONE.
  - `load_en` while busy: memory unchanged, `load_err`=1 for 1 cycle.
  - `load_addr` >= DEPTH: write dropped, `load_err` pulses.
- Ordering: a write to address A in the same cycle as `start` is visible if the first read of A occurs at least one cycle later. Writes never overlap execution.
- pc never wraps; the L-1 terminator always precedes the address limit.

Optional Feature:
- Macro: `INSTR_SEQ_BREAKPOINT_EN`.
- When defined, three ports are added:
  - `bp_en` in 1.
  - `bp_addr` in AW.
  - `bp_hit` out 1, reset 0.
- Breakpoint trigger: any transition into a slot whose pc equals `bp_addr` while `bp_en`=1 goes to WAIT_STEP instead of ISSUE.
  - This includes the start transition for pc 0.
- While paused at the breakpoint, `bp_hit`=1.
- `step` issues the breakpointed instruction and clears `bp_hit`; that slot does not re-trigger.
- `abort` clears `bp_hit`.
- When undefined: the ports are absent and sequencing is exactly as in Behaviour.

Test Plan:
- Load mem[0..2] = 0x123, 0x456, 0x789; `prog_len`=3; pulse `start` → each instruction is held 3 cycles with `instr_valid`=1 for 9 consecutive cycles; `done`=1 on the cycle after the last slot; `pc`=2.
- `step_mode`=1, same program, `start` → slot 0 runs, then WAIT_STEP with `pc`=1 and `instruction`=0; each `step` pulse releases exactly one 3-cycle slot.
- `abort` on phase 1 of slot 1 → next cycle IDLE, `pc`=0, `instruction`=0, `busy`=0, `done`=0; a subsequent `start` reruns from 0x123.
- `load_en` during ISSUE → `load_err` 1-cycle pulse, memory unchanged (verified on rerun). `prog_len`=0 with `start` → DONE next cycle with `instr_valid` never asserted. `prog_len`=300 with DEPTH=256 → 256 slots issued.
- Same-cycle `abort` and `step` in WAIT_STEP → IDLE; no slot is issued.
- (`INSTR_SEQ_BREAKPOINT_EN`) `bp_en`=1, `bp_addr`=1, free-run → after slot 0, `bp_hit`=1 and `pc`=1; `step` issues 0x456 and slot 2 follows back-to-back; `done` is set.
